mcpu_cache_ic_arb: RTL and testbench
====================================

# mcpu_cache_ic_arb

Two-requester arbiter for the single instruction-cache port. It shares the cache between the core's fetch unit (`f2ic_*`) and a debug/loader reader (`dbg2ic_*`) using round-robin, one outstanding request at a time. It sits between `MCPU_core` and the icache (dummy or real) in the core wrapper. It tracks the owner of the in-flight request and routes the response back to that owner. If the owner abandons the request, the arbiter drains the downstream access and discards the response.

## Interface
- No parameters; address width 28, packet width 128 fixed.
- `clkrst_core_clk` in 1: sole clock, rising edge.
- `clkrst_core_rst_n` in 1: asynchronous active-low reset.
- `f2ic_valid` in 1: fetch request; held high with stable `f2ic_paddr` until `ic2f_ready` is sampled high.
- `f2ic_paddr` in 28: fetch 16-byte-line physical address.
- `ic2f_ready` out 1: one-cycle completion pulse to fetch.
- `ic2f_packet` out 128: response data to fetch; valid only with `ic2f_ready`.
- `dbg2ic_valid` in 1: debug request; same rules as fetch.
- `dbg2ic_paddr` in 28: debug address.
- `ic2dbg_ready` out 1: completion pulse to debug.
- `ic2dbg_packet` out 128: response data to debug.
- `arb2ic_valid` out 1: downstream request, registered.
- `arb2ic_paddr` out 28: downstream address, registered and latched at grant.
- `ic2arb_ready` in 1: downstream completion; may be high in the first cycle of `arb2ic_valid`.
- `ic2arb_packet` in 128: downstream data.

## Operation
- State machine with three states: IDLE, BUSY and DRAIN. Registers: `owner` (0 = fetch, 1 = debug) and `last_grant`.
- **IDLE**
  - If any valid is high: pick a winner and latch the winner's paddr into `arb2ic_paddr`.
  - Set `owner` and `last_grant` to the winner, set `arb2ic_valid` to 1, and go to BUSY.
  - If both valids are high, grant to the requester that is not `last_grant`.
- **BUSY**
  - If `ic2arb_ready` is high and the owner's valid is high: pulse the owner's ready. `arb2ic_valid` goes to 0 and the state goes to IDLE.
  - If `ic2arb_ready` is high and the owner's valid is low: the response is discarded. `arb2ic_valid` goes to 0 and the state goes to IDLE.
  - If `ic2arb_ready` is low and the owner's valid is low: abort; go to DRAIN.
  - Otherwise: stay in BUSY.
- **DRAIN**
  - `arb2ic_valid` and `arb2ic_paddr` are held.
  - When `ic2arb_ready` is seen: discard the response, drop `arb2ic_valid`, and go to IDLE.
  - No requester ready is asserted in DRAIN.
  - A requester that re-raises valid during DRAIN is a new request, arbitrated from IDLE.
- **Ready routing**
  - `ic2f_ready = BUSY && owner==0 && f2ic_valid && ic2arb_ready`; `ic2dbg_ready` is the same with `owner==1`.
  - Both packet outputs are wired directly from `ic2arb_packet`.
- **Latched address**
  - The paddr is latched only at grant.
  - Requester paddr changes while waiting are ignored; they are a protocol violation, and the latched address is used.
- **Ready exclusivity:** the two requester readies are never high in the same cycle.

## Timing
- **Reset values**
  - State: IDLE.
  - `arb2ic_valid`: 0.
  - `arb2ic_paddr`: 0.
  - `owner`: 0.
  - `last_grant`: 1, so fetch wins the first tie.
  - `ic2f_ready` and `ic2dbg_ready`: 0.
- **Request latency**
  - A valid first sampled high at edge N produces `arb2ic_valid` high in cycle N+1.
  - With a zero-wait cache, the requester's ready is high in cycle N+1.
- **Throughput**
  - Minimum is one request per 2 cycles, because of the mandatory IDLE cycle.
  - Under continuous contention, grants alternate fetch, debug, fetch, and so on.
- **Reset mid-operation:** an asserted reset immediately returns all state to reset values. Any in-flight downstream request is dropped without a response.

## Configuration
- `MCPU_IC_ARB_STATS_EN`
  - **Defined:** adds outputs `arb_stat_fetch_grants` and `arb_stat_dbg_grants`, each 16 bits.
    - Each counter increments on its requester's grant (the IDLE to BUSY transition) and saturates at 16'hFFFF.
    - Both counters reset to 0.
  - **Undefined:** these ports and counters are absent; behaviour is otherwise identical.

## Test plan
- **Fetch only, zero-wait:** `f2ic_valid`=1 with paddr 28'h0000100 at edge 0, cache ready is combinational.
  - `arb2ic_paddr` = 28'h0000100 and `ic2f_ready` = 1 in cycle 1, with the packet equal to `ic2arb_packet`.
  - `arb2ic_valid` = 0 in cycle 2.
- **Tie after reset:** both valids high from reset release.
  - Fetch is granted first, then debug.
  - Over 8 completions the grants alternate exactly, 4 to each requester.
- **Slow cache:** `ic2arb_ready` is delayed by 3 cycles.
  - `arb2ic_valid` and paddr stay stable for 4 cycles.
  - Exactly one requester ready pulse is produced.
- **Fetch abort:** fetch drops valid in BUSY with cache ready 2 cycles later.
  - The arbiter enters DRAIN and never asserts `ic2f_ready`.
  - A pending debug request is granted in the cycle after the drain completes.
- **Reset mid-request:** assert `clkrst_core_rst_n`=0 while BUSY.
  - `arb2ic_valid`=0 immediately.
  - After release, the first tie goes to fetch.
  - With `MCPU_IC_ARB_STATS_EN` defined, both counters read 0.

Source files
------------

// File: rtl/mcpu_cache_ic_arb_if.sv
// Signal bundle between the fetch unit, the debug reader, the icache arbiter and the icache.
// The arbiter grant counters appear only when MCPU_IC_ARB_STATS_EN is defined.
interface mcpu_cache_ic_arb_if;
  logic         f2ic_valid;
  logic [27:0]  f2ic_paddr;
  logic         ic2f_ready;
  logic [127:0] ic2f_packet;

  logic         dbg2ic_valid;
  logic [27:0]  dbg2ic_paddr;
  logic         ic2dbg_ready;
  logic [127:0] ic2dbg_packet;

  logic         arb2ic_valid;
  logic [27:0]  arb2ic_paddr;
  logic         ic2arb_ready;
  logic [127:0] ic2arb_packet;

`ifdef MCPU_IC_ARB_STATS_EN
  logic [15:0]  arb_stat_fetch_grants;
  logic [15:0]  arb_stat_dbg_grants;
`endif

  // Arbiter side: serves both requesters and masters the icache port.
  modport master (
`ifdef MCPU_IC_ARB_STATS_EN
    output arb_stat_fetch_grants, arb_stat_dbg_grants,
`endif
    input  f2ic_valid, f2ic_paddr, dbg2ic_valid, dbg2ic_paddr,
    input  ic2arb_ready, ic2arb_packet,
    output ic2f_ready, ic2f_packet, ic2dbg_ready, ic2dbg_packet,
    output arb2ic_valid, arb2ic_paddr
  );

  // Environment side: requesters and icache.
  modport slave (
`ifdef MCPU_IC_ARB_STATS_EN
    input  arb_stat_fetch_grants, arb_stat_dbg_grants,
`endif
    output f2ic_valid, f2ic_paddr, dbg2ic_valid, dbg2ic_paddr,
    output ic2arb_ready, ic2arb_packet,
    input  ic2f_ready, ic2f_packet, ic2dbg_ready, ic2dbg_packet,
    input  arb2ic_valid, arb2ic_paddr
  );
endinterface

// File: rtl/mcpu_cache_ic_arb.sv
// Round-robin arbiter sharing the icache port between fetch and debug, one request in flight.
// Optional saturating grant counters are enabled by defining MCPU_IC_ARB_STATS_EN.
module mcpu_cache_ic_arb (
  input  logic                clkrst_core_clk,
  input  logic                clkrst_core_rst_n,
  mcpu_cache_ic_arb_if.master bus
);
  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    BUSY  = 2'd1,
    DRAIN = 2'd2
  } state_t;

  state_t      state_q, state_d;
  logic        owner_q, owner_d;
  logic        last_q, last_d;
  logic        req_vld_q, req_vld_d;
  logic [27:0] paddr_q, paddr_d;

  logic any_req;
  logic winner;
  logic owner_vld;
  logic grant;

  assign any_req   = bus.f2ic_valid | bus.dbg2ic_valid;
  // Debug wins when it is alone, or on a tie when fetch had the last grant.
  assign winner    = bus.dbg2ic_valid & (~bus.f2ic_valid | ~last_q);
  assign owner_vld = owner_q ? bus.dbg2ic_valid : bus.f2ic_valid;
  assign grant     = (state_q == IDLE) && any_req;

  always_comb begin
    state_d   = state_q;
    owner_d   = owner_q;
    last_d    = last_q;
    req_vld_d = req_vld_q;
    paddr_d   = paddr_q;
    case (state_q)
      IDLE: begin
        if (any_req) begin
          paddr_d   = winner ? bus.dbg2ic_paddr : bus.f2ic_paddr;
          owner_d   = winner;
          last_d    = winner;
          req_vld_d = 1'b1;
          state_d   = BUSY;
        end
      end
      BUSY: begin
        if (bus.ic2arb_ready) begin
          req_vld_d = 1'b0;
          state_d   = IDLE;
        end else if (!owner_vld) begin
          state_d   = DRAIN;
        end
      end
      DRAIN: begin
        // Downstream access must complete before the port can be reused.
        if (bus.ic2arb_ready) begin
          req_vld_d = 1'b0;
          state_d   = IDLE;
        end
      end
      default: begin
        req_vld_d = 1'b0;
        state_d   = IDLE;
      end
    endcase
  end

  always_ff @(posedge clkrst_core_clk or negedge clkrst_core_rst_n) begin
    if (!clkrst_core_rst_n) begin
      state_q   <= IDLE;
      owner_q   <= 1'b0;
      last_q    <= 1'b1;
      req_vld_q <= 1'b0;
      paddr_q   <= '0;
    end else begin
      state_q   <= state_d;
      owner_q   <= owner_d;
      last_q    <= last_d;
      req_vld_q <= req_vld_d;
      paddr_q   <= paddr_d;
    end
  end

  assign bus.arb2ic_valid  = req_vld_q;
  assign bus.arb2ic_paddr  = paddr_q;
  assign bus.ic2f_ready    = (state_q == BUSY) && !owner_q && bus.f2ic_valid   && bus.ic2arb_ready;
  assign bus.ic2dbg_ready  = (state_q == BUSY) &&  owner_q && bus.dbg2ic_valid && bus.ic2arb_ready;
  assign bus.ic2f_packet   = bus.ic2arb_packet;
  assign bus.ic2dbg_packet = bus.ic2arb_packet;

`ifdef MCPU_IC_ARB_STATS_EN
  logic [15:0] fetch_grants_q;
  logic [15:0] dbg_grants_q;

  function automatic logic [15:0] sat_inc(input logic [15:0] v);
    return (v == 16'hFFFF) ? v : v + 16'd1;
  endfunction

  always_ff @(posedge clkrst_core_clk or negedge clkrst_core_rst_n) begin
    if (!clkrst_core_rst_n) begin
      fetch_grants_q <= '0;
      dbg_grants_q   <= '0;
    end else if (grant) begin
      if (winner) dbg_grants_q   <= sat_inc(dbg_grants_q);
      else        fetch_grants_q <= sat_inc(fetch_grants_q);
    end
  end

  assign bus.arb_stat_fetch_grants = fetch_grants_q;
  assign bus.arb_stat_dbg_grants   = dbg_grants_q;
`endif
endmodule

// File: tb/tb_mcpu_cache_ic_arb.sv
// Directed self-checking bench for mcpu_cache_ic_arb with a programmable-latency icache model.
module tb_mcpu_cache_ic_arb;
  logic clk;
  logic rst_n;
  int   checks;
  int   failures;
  int   cache_wait;
  int   cnt;

  mcpu_cache_ic_arb_if bus ();

  mcpu_cache_ic_arb dut (
    .clkrst_core_clk   (clk),
    .clkrst_core_rst_n (rst_n),
    .bus               (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Icache model: completes after cache_wait extra cycles, data derived from the address.
  always @(posedge clk) begin
    if (!bus.arb2ic_valid || bus.ic2arb_ready) cnt <= 0;
    else cnt <= cnt + 1;
  end
  assign bus.ic2arb_ready  = bus.arb2ic_valid && (cnt == cache_wait);
  assign bus.ic2arb_packet = {4{4'hA, bus.arb2ic_paddr}};

  task automatic step;
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset;
    rst_n = 1'b0;
    cache_wait = 0;
    bus.f2ic_valid = 1'b1;
    bus.f2ic_paddr = 28'h0000010;
    bus.dbg2ic_valid = 1'b0;
    bus.dbg2ic_paddr = 28'h0;
    step; step;
    @(negedge clk);
    checks++; if (bus.arb2ic_valid !== 1'b0) begin failures++; $display("FAIL rst_valid: got %0b want 0", bus.arb2ic_valid); end
    checks++; if (bus.arb2ic_paddr !== 28'h0) begin failures++; $display("FAIL rst_paddr: got %h want 0", bus.arb2ic_paddr); end
    checks++; if (bus.ic2f_ready !== 1'b0) begin failures++; $display("FAIL rst_f_ready: got %0b want 0", bus.ic2f_ready); end
    checks++; if (bus.ic2dbg_ready !== 1'b0) begin failures++; $display("FAIL rst_dbg_ready: got %0b want 0", bus.ic2dbg_ready); end
`ifdef MCPU_IC_ARB_STATS_EN
    checks++; if (bus.arb_stat_fetch_grants !== 16'd0) begin failures++; $display("FAIL rst_stat_f: got %0d want 0", bus.arb_stat_fetch_grants); end
    checks++; if (bus.arb_stat_dbg_grants !== 16'd0) begin failures++; $display("FAIL rst_stat_d: got %0d want 0", bus.arb_stat_dbg_grants); end
`endif
    step;
    bus.f2ic_valid = 1'b0;
    rst_n = 1'b1;
    step;
  endtask

  task automatic test_fetch_zero_wait;
    step;
    bus.f2ic_valid = 1'b1;
    bus.f2ic_paddr = 28'h0000100;
    step;
    @(negedge clk);
    checks++; if (bus.arb2ic_valid !== 1'b1) begin failures++; $display("FAIL zw_valid: got %0b want 1", bus.arb2ic_valid); end
    checks++; if (bus.arb2ic_paddr !== 28'h0000100) begin failures++; $display("FAIL zw_paddr: got %h want 0000100", bus.arb2ic_paddr); end
    checks++; if (bus.ic2f_ready !== 1'b1) begin failures++; $display("FAIL zw_f_ready: got %0b want 1", bus.ic2f_ready); end
    checks++; if (bus.ic2dbg_ready !== 1'b0) begin failures++; $display("FAIL zw_dbg_ready: got %0b want 0", bus.ic2dbg_ready); end
    checks++; if (bus.ic2f_packet !== 128'hA0000100_A0000100_A0000100_A0000100) begin failures++; $display("FAIL zw_packet: got %h want A0000100 x4", bus.ic2f_packet); end
    step;
    bus.f2ic_valid = 1'b0;
    @(negedge clk);
    checks++; if (bus.arb2ic_valid !== 1'b0) begin failures++; $display("FAIL zw_valid_drop: got %0b want 0", bus.arb2ic_valid); end
    checks++; if (bus.ic2f_ready !== 1'b0) begin failures++; $display("FAIL zw_f_ready_drop: got %0b want 0", bus.ic2f_ready); end
    step;
  endtask

  task automatic test_tie_alternate;
    int n, cyc, f_n, d_n, exp_who;
    logic [27:0] exp_paddr;
    rst_n = 1'b0;
    bus.f2ic_valid = 1'b1;
    bus.f2ic_paddr = 28'h0000200;
    bus.dbg2ic_valid = 1'b1;
    bus.dbg2ic_paddr = 28'h0000300;
    cache_wait = 0;
    step; step;
    rst_n = 1'b1;
    n = 0; cyc = 0; f_n = 0; d_n = 0;
    while (n < 8 && cyc < 40) begin
      @(negedge clk);
      checks++; if (bus.ic2f_ready && bus.ic2dbg_ready) begin failures++; $display("FAIL tie_excl: got both readies high want at most one"); end
      if (bus.ic2f_ready || bus.ic2dbg_ready) begin
        exp_who   = n % 2;
        exp_paddr = (exp_who == 1) ? 28'h0000300 : 28'h0000200;
        checks++; if (int'(bus.ic2dbg_ready) !== exp_who) begin failures++; $display("FAIL tie_order[%0d]: got dbg=%0b want dbg=%0d", n, bus.ic2dbg_ready, exp_who); end
        checks++; if (bus.arb2ic_paddr !== exp_paddr) begin failures++; $display("FAIL tie_paddr[%0d]: got %h want %h", n, bus.arb2ic_paddr, exp_paddr); end
        if (bus.ic2dbg_ready) d_n++; else f_n++;
        n++;
      end
      step;
      cyc++;
    end
    bus.f2ic_valid = 1'b0;
    bus.dbg2ic_valid = 1'b0;
    checks++; if (n !== 8) begin failures++; $display("FAIL tie_timeout: got %0d completions want 8", n); end
    checks++; if (f_n !== 4) begin failures++; $display("FAIL tie_f_count: got %0d want 4", f_n); end
    checks++; if (d_n !== 4) begin failures++; $display("FAIL tie_d_count: got %0d want 4", d_n); end
    step;
    @(negedge clk);
    checks++; if (bus.arb2ic_valid !== 1'b0) begin failures++; $display("FAIL tie_idle: got %0b want 0", bus.arb2ic_valid); end
`ifdef MCPU_IC_ARB_STATS_EN
    checks++; if (bus.arb_stat_fetch_grants !== 16'd4) begin failures++; $display("FAIL tie_stat_f: got %0d want 4", bus.arb_stat_fetch_grants); end
    checks++; if (bus.arb_stat_dbg_grants !== 16'd4) begin failures++; $display("FAIL tie_stat_d: got %0d want 4", bus.arb_stat_dbg_grants); end
`endif
  endtask

  task automatic test_slow_cache;
    int pulses, f_pulses, rcyc;
    logic drop;
    cache_wait = 3;
    step;
    bus.dbg2ic_valid = 1'b1;
    bus.dbg2ic_paddr = 28'h0000400;
    pulses = 0; f_pulses = 0; rcyc = 0; drop = 1'b0;
    for (int c = 1; c <= 8; c++) begin
      step;
      if (drop) bus.dbg2ic_valid = 1'b0;
      if (c == 2) bus.dbg2ic_paddr = 28'h00004FF;
      @(negedge clk);
      if (c <= 4) begin
        checks++; if (bus.arb2ic_valid !== 1'b1) begin failures++; $display("FAIL slow_valid[%0d]: got %0b want 1", c, bus.arb2ic_valid); end
        checks++; if (bus.arb2ic_paddr !== 28'h0000400) begin failures++; $display("FAIL slow_paddr[%0d]: got %h want 0000400", c, bus.arb2ic_paddr); end
      end
      if (c == 5) begin
        checks++; if (bus.arb2ic_valid !== 1'b0) begin failures++; $display("FAIL slow_valid_drop: got %0b want 0", bus.arb2ic_valid); end
      end
      if (bus.ic2f_ready) f_pulses++;
      if (bus.ic2dbg_ready) begin
        pulses++;
        rcyc = c;
        drop = 1'b1;
        checks++; if (bus.ic2dbg_packet !== 128'hA0000400_A0000400_A0000400_A0000400) begin failures++; $display("FAIL slow_packet: got %h want A0000400 x4", bus.ic2dbg_packet); end
      end
    end
    checks++; if (pulses !== 1) begin failures++; $display("FAIL slow_pulses: got %0d want 1", pulses); end
    checks++; if (rcyc !== 4) begin failures++; $display("FAIL slow_ready_cycle: got %0d want 4", rcyc); end
    checks++; if (f_pulses !== 0) begin failures++; $display("FAIL slow_f_pulses: got %0d want 0", f_pulses); end
  endtask

  task automatic test_fetch_abort;
    int f_pulses;
    cache_wait = 3;
    f_pulses = 0;
    step;
    bus.f2ic_valid = 1'b1;
    bus.f2ic_paddr = 28'h0000500;
    for (int c = 1; c <= 7; c++) begin
      step;
      if (c == 1) begin bus.dbg2ic_valid = 1'b1; bus.dbg2ic_paddr = 28'h0000600; end
      if (c == 2) bus.f2ic_valid = 1'b0;
      if (c == 5) cache_wait = 0;
      if (c == 7) bus.dbg2ic_valid = 1'b0;
      @(negedge clk);
      if (bus.ic2f_ready) f_pulses++;
      if (c <= 4) begin
        checks++; if (bus.arb2ic_valid !== 1'b1 || bus.arb2ic_paddr !== 28'h0000500) begin failures++; $display("FAIL abort_hold[%0d]: got v=%0b a=%h want v=1 a=0000500", c, bus.arb2ic_valid, bus.arb2ic_paddr); end
      end
      if (c <= 5) begin
        checks++; if (bus.ic2dbg_ready !== 1'b0) begin failures++; $display("FAIL abort_dbg_early[%0d]: got %0b want 0", c, bus.ic2dbg_ready); end
      end
      if (c == 5) begin
        checks++; if (bus.arb2ic_valid !== 1'b0) begin failures++; $display("FAIL abort_idle: got %0b want 0", bus.arb2ic_valid); end
      end
      if (c == 6) begin
        checks++; if (bus.arb2ic_valid !== 1'b1 || bus.arb2ic_paddr !== 28'h0000600) begin failures++; $display("FAIL abort_dbg_grant: got v=%0b a=%h want v=1 a=0000600", bus.arb2ic_valid, bus.arb2ic_paddr); end
        checks++; if (bus.ic2dbg_ready !== 1'b1) begin failures++; $display("FAIL abort_dbg_ready: got %0b want 1", bus.ic2dbg_ready); end
      end
      if (c == 7) begin
        checks++; if (bus.arb2ic_valid !== 1'b0) begin failures++; $display("FAIL abort_end: got %0b want 0", bus.arb2ic_valid); end
      end
    end
    checks++; if (f_pulses !== 0) begin failures++; $display("FAIL abort_f_ready: got %0d pulses want 0", f_pulses); end
  endtask

  task automatic test_reset_mid;
    cache_wait = 5;
    step;
    bus.f2ic_valid = 1'b1;
    bus.f2ic_paddr = 28'h0000700;
    step; step;
    @(negedge clk);
    checks++; if (bus.arb2ic_valid !== 1'b1) begin failures++; $display("FAIL mid_busy: got %0b want 1", bus.arb2ic_valid); end
    step;
    rst_n = 1'b0;
    bus.dbg2ic_valid = 1'b1;
    bus.dbg2ic_paddr = 28'h0000800;
    cache_wait = 0;
    #1;
    checks++; if (bus.arb2ic_valid !== 1'b0) begin failures++; $display("FAIL mid_valid: got %0b want 0", bus.arb2ic_valid); end
    checks++; if (bus.ic2f_ready !== 1'b0 || bus.ic2dbg_ready !== 1'b0) begin failures++; $display("FAIL mid_ready: got f=%0b d=%0b want 0 0", bus.ic2f_ready, bus.ic2dbg_ready); end
`ifdef MCPU_IC_ARB_STATS_EN
    checks++; if (bus.arb_stat_fetch_grants !== 16'd0 || bus.arb_stat_dbg_grants !== 16'd0) begin failures++; $display("FAIL mid_stats: got f=%0d d=%0d want 0 0", bus.arb_stat_fetch_grants, bus.arb_stat_dbg_grants); end
`endif
    step; step;
    rst_n = 1'b1;
    step;
    @(negedge clk);
    checks++; if (bus.arb2ic_paddr !== 28'h0000700) begin failures++; $display("FAIL mid_tie_paddr: got %h want 0000700", bus.arb2ic_paddr); end
    checks++; if (bus.ic2f_ready !== 1'b1 || bus.ic2dbg_ready !== 1'b0) begin failures++; $display("FAIL mid_tie_owner: got f=%0b d=%0b want 1 0", bus.ic2f_ready, bus.ic2dbg_ready); end
    step;
    bus.f2ic_valid = 1'b0;
    bus.dbg2ic_valid = 1'b0;
    step;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout want completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    checks = 0;
    failures = 0;
    test_reset();
    test_fetch_zero_wait();
    test_tie_alternate();
    test_slow_cache();
    test_fetch_abort();
    test_reset_mid();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
